// File: rtl/serial_operand_serializer.sv
// serial_operand_serializer
// Feeds an MSB-first serial comparator. A pair of WIDTH-bit operands is
// accepted over valid/ready, then the comparator is cleared for one cycle,
// then both operands are shifted out one bit per cycle, MSB first. On the
// last bit the comparator flags are captured into a registered result that
// is flagged valid for exactly one cycle. res_err marks flags that were not
// exactly one-hot.
//
// The next pair can be accepted on the same edge as the last bit, which
// removes the idle cycle between pairs. Throughput is then one pair every
// WIDTH+1 cycles.

module serial_operand_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             cmp_clr,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_valid,
  input  logic             cmp_less,
  input  logic             cmp_eq,
  input  logic             cmp_greater,
  output logic             res_valid,
  output logic             res_less,
  output logic             res_eq,
  output logic             res_greater,
  output logic             res_err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic           last_bit;
  logic           accept;

  // The last SHIFT cycle is both the capture point and a handshake slot.
  assign last_bit = (state == SHIFT) && (cnt == '0);
  assign accept   = in_valid && in_ready;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: CLEAR always lasts one cycle, SHIFT runs until the counter hits zero.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? CLEAR : IDLE;
      CLEAR:   state_next = SHIFT;
      SHIFT:   begin
        if (cnt == '0) begin
          state_next = accept ? CLEAR : IDLE;
        end else begin
          state_next = SHIFT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state and counter only, so in_ready never depends on in_valid.
  always_comb begin
    in_ready  = 1'b0;
    cmp_clr   = 1'b0;
    ser_valid = 1'b0;
    ser_a     = 1'b0;
    ser_b     = 1'b0;
    case (state)
      IDLE:  in_ready = 1'b1;
      CLEAR: cmp_clr  = 1'b1;
      SHIFT: begin
        in_ready  = (cnt == '0);
        ser_valid = 1'b1;
        ser_a     = sh_a[WIDTH-1];
        ser_b     = sh_b[WIDTH-1];
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Operand shift registers and bit counter; a new pair loads over any shift in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a <= '0;
      sh_b <= '0;
      cnt  <= '0;
    end else if (accept) begin
      sh_a <= in_a;
      sh_b <= in_b;
      cnt  <= CW'(WIDTH - 1);
    end else if (state == SHIFT) begin
      sh_a <= {sh_a[WIDTH-2:0], 1'b0};
      sh_b <= {sh_b[WIDTH-2:0], 1'b0};
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Capture the comparator flags on the last bit and pulse res_valid for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid   <= 1'b0;
      res_less    <= 1'b0;
      res_eq      <= 1'b0;
      res_greater <= 1'b0;
      res_err     <= 1'b0;
    end else begin
      res_valid <= last_bit;
      if (last_bit) begin
        res_less    <= cmp_less;
        res_eq      <= cmp_eq;
        res_greater <= cmp_greater;
        res_err     <= !$onehot({cmp_less, cmp_eq, cmp_greater});
      end
    end
  end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// tb_serial_operand_serializer
// Drives serial_operand_serializer together with a behavioural MSB-first
// comparator. It checks the CLEAR/SHIFT timing, the serial bit order, the
// captured result, back-to-back streaming, mid-shift reset and the
// non-one-hot error flag.

module tb_serial_operand_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         cmp_clr;
  logic         ser_a;
  logic         ser_b;
  logic         ser_valid;
  logic         cmp_less;
  logic         cmp_eq;
  logic         cmp_greater;
  logic         res_valid;
  logic         res_less;
  logic         res_eq;
  logic         res_greater;
  logic         res_err;
  logic         force_err;

  int tests_run;
  int tests_failed;

  serial_operand_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .cmp_clr    (cmp_clr),
    .ser_a      (ser_a),
    .ser_b      (ser_b),
    .ser_valid  (ser_valid),
    .cmp_less   (cmp_less),
    .cmp_eq     (cmp_eq),
    .cmp_greater(cmp_greater),
    .res_valid  (res_valid),
    .res_less   (res_less),
    .res_eq     (res_eq),
    .res_greater(res_greater),
    .res_err    (res_err)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural MSB-first comparator: the first differing bit decides.
  typedef enum {C_EQ, C_LT, C_GT} cmp_state_t;
  cmp_state_t cmp_st = C_EQ;

  // Remember the decision once the first differing bit has been seen; cmp_clr restarts it.
  always @(posedge clk) begin
    if (cmp_clr) begin
      cmp_st <= C_EQ;
    end else if (ser_valid && cmp_st == C_EQ && ser_a != ser_b) begin
      cmp_st <= ser_a ? C_GT : C_LT;
    end
  end

  // Comparator flags include the current bit combinationally; force_err breaks one-hotness.
  always_comb begin
    cmp_less    = 1'b0;
    cmp_eq      = 1'b0;
    cmp_greater = 1'b0;
    if (force_err) begin
      cmp_less    = 1'b1;
      cmp_greater = 1'b1;
    end else if (cmp_st == C_LT) begin
      cmp_less = 1'b1;
    end else if (cmp_st == C_GT) begin
      cmp_greater = 1'b1;
    end else if (ser_valid && ser_a != ser_b) begin
      cmp_greater = ser_a;
      cmp_less    = ser_b;
    end else begin
      cmp_eq = 1'b1;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         force_e;
    logic         exp_less;
    logic         exp_eq;
    logic         exp_greater;
    logic         exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check_output(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Offer one pair, follow it cycle by cycle and check serial bits and result.
  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic force_e,
                                input logic exp_l, input logic exp_e, input logic exp_g, input logic exp_r);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_output("ready_wait", W'(in_ready), W'(1));
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    force_err = force_e;
    @(negedge clk);
    check_output("clr_cycle_cmp_clr", W'(cmp_clr), W'(1));
    check_output("clr_cycle_ser_valid", W'(ser_valid), W'(0));
    check_output("clr_cycle_in_ready", W'(in_ready), W'(0));
    in_valid = 1'(($urandom % 2));
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    for (int k = 2; k <= W + 1; k++) begin
      @(negedge clk);
      check_output("shift_ser_valid", W'(ser_valid), W'(1));
      check_output("shift_ser_a", W'(ser_a), W'(a[W+1-k]));
      check_output("shift_ser_b", W'(ser_b), W'(b[W+1-k]));
      check_output("shift_in_ready", W'(in_ready), W'(k == W + 1));
      check_output("shift_cmp_clr", W'(cmp_clr), W'(0));
      check_output("shift_res_valid", W'(res_valid), W'(0));
      if (k == W + 1) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'(($urandom % 2));
        in_a     = W'($urandom);
        in_b     = W'($urandom);
      end
    end
    @(negedge clk);
    check_output("res_valid", W'(res_valid), W'(1));
    check_output("res_less", W'(res_less), W'(exp_l));
    check_output("res_eq", W'(res_eq), W'(exp_e));
    check_output("res_greater", W'(res_greater), W'(exp_g));
    check_output("res_err", W'(res_err), W'(exp_r));
    check_output("after_in_ready", W'(in_ready), W'(1));
    force_err = 1'b0;
  endtask

  // Three pairs with in_valid held high: one pair every W+1 cycles, results in order.
  task automatic back_to_back();
    logic [W-1:0] bb_a[3];
    logic [W-1:0] bb_b[3];
    int p;
    int ph;
    bb_a[0] = 8'h01; bb_b[0] = 8'h02;
    bb_a[1] = 8'hFF; bb_b[1] = 8'h00;
    bb_a[2] = 8'h55; bb_b[2] = 8'h55;
    in_valid = 1'b1;
    in_a     = bb_a[0];
    in_b     = bb_b[0];
    for (int t = 1; t <= 3 * (W + 1) + 1; t++) begin
      @(negedge clk);
      p  = (t - 1) / (W + 1);
      ph = (t - 1) % (W + 1) + 1;
      if (p == 3) begin
        check_output("b2b_final_in_ready", W'(in_ready), W'(1));
        check_output("b2b_final_cmp_clr", W'(cmp_clr), W'(0));
        check_output("b2b_final_res_valid", W'(res_valid), W'(1));
        check_output("b2b_final_res_eq", W'(res_eq), W'(bb_a[2] == bb_b[2]));
        check_output("b2b_final_res_less", W'(res_less), W'(bb_a[2] < bb_b[2]));
        check_output("b2b_final_res_greater", W'(res_greater), W'(bb_a[2] > bb_b[2]));
      end else begin
        check_output("b2b_cmp_clr", W'(cmp_clr), W'(ph == 1));
        check_output("b2b_in_ready", W'(in_ready), W'(ph == W + 1));
        check_output("b2b_ser_valid", W'(ser_valid), W'(ph != 1));
        check_output("b2b_res_valid", W'(res_valid), W'(ph == 1 && p > 0));
        if (ph == 1 && p > 0) begin
          check_output("b2b_res_less", W'(res_less), W'(bb_a[p-1] < bb_b[p-1]));
          check_output("b2b_res_eq", W'(res_eq), W'(bb_a[p-1] == bb_b[p-1]));
          check_output("b2b_res_greater", W'(res_greater), W'(bb_a[p-1] > bb_b[p-1]));
          check_output("b2b_res_err", W'(res_err), W'(0));
        end
        if (ph == W + 1) begin
          if (p < 2) begin
            in_a = bb_a[p+1];
            in_b = bb_b[p+1];
          end else begin
            in_valid = 1'b0;
          end
        end
      end
    end
  endtask

  // Reset during the 4th SHIFT cycle: everything returns to reset values and no result appears.
  task automatic mid_shift_reset();
    in_valid = 1'b1;
    in_a     = 8'hF0;
    in_b     = 8'h0F;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_output("rst_pre_ser_valid", W'(ser_valid), W'(1));
    check_output("rst_pre_ser_a", W'(ser_a), W'(1));
    check_output("rst_pre_ser_b", W'(ser_b), W'(0));
    rst_n = 1'b0;
    #1;
    check_output("rst_ser_valid", W'(ser_valid), W'(0));
    check_output("rst_ser_a", W'(ser_a), W'(0));
    check_output("rst_cmp_clr", W'(cmp_clr), W'(0));
    check_output("rst_res_valid", W'(res_valid), W'(0));
    check_output("rst_res_flags", W'({res_less, res_eq, res_greater, res_err}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      check_output("rst_no_res_valid", W'(res_valid), W'(0));
      check_output("rst_idle_in_ready", W'(in_ready), W'(1));
    end
  endtask

  // Main sequence: reset, table vectors, reset abort, streaming, then random pairs.
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_a         = '0;
    in_b         = '0;
    force_err    = 1'b0;

    vecs[0] = '{a: 8'hA5, b: 8'hA5, force_e: 1'b0, exp_less: 1'b0, exp_eq: 1'b1, exp_greater: 1'b0, exp_err: 1'b0};
    vecs[1] = '{a: 8'h80, b: 8'h7F, force_e: 1'b0, exp_less: 1'b0, exp_eq: 1'b0, exp_greater: 1'b1, exp_err: 1'b0};
    vecs[2] = '{a: 8'h12, b: 8'h13, force_e: 1'b0, exp_less: 1'b1, exp_eq: 1'b0, exp_greater: 1'b0, exp_err: 1'b0};
    vecs[3] = '{a: 8'h03, b: 8'h04, force_e: 1'b0, exp_less: 1'b1, exp_eq: 1'b0, exp_greater: 1'b0, exp_err: 1'b0};
    vecs[4] = '{a: 8'h5A, b: 8'h3C, force_e: 1'b1, exp_less: 1'b1, exp_eq: 1'b0, exp_greater: 1'b1, exp_err: 1'b1};

    #1;
    check_output("reset_in_ready", W'(in_ready), W'(1));
    check_output("reset_ser_valid", W'(ser_valid), W'(0));
    check_output("reset_cmp_clr", W'(cmp_clr), W'(0));
    check_output("reset_res_valid", W'(res_valid), W'(0));
    check_output("reset_res_flags", W'({res_less, res_eq, res_greater, res_err}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].force_e,
                     vecs[i].exp_less, vecs[i].exp_eq, vecs[i].exp_greater, vecs[i].exp_err);
    end

    mid_shift_reset();
    apply_stimulus(8'h03, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    back_to_back();

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = ($urandom % 4 == 0) ? ra : W'($urandom);
      apply_stimulus(ra, rb, 1'b0, ra < rb, ra == rb, ra > rb, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_operand_serializer.md
# serial_operand_serializer

Upstream feeder for the MSB-first serial comparator. The block accepts a pair of WIDTH-bit operands over a valid/ready handshake, clears the comparator, then shifts both operands out one bit per cycle, most significant bit first. On the last bit it captures the comparator's three flags and presents them as a registered, one-cycle-valid result, with an error flag if the flags are not one-hot.

## Interface
- WIDTH, 8, operand width in bits; legal range ≥ 2
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair available
- in_ready  out  1  block can accept a pair this cycle; combinational from state and counter only, never from in_valid
- in_a  in  WIDTH  operand A, sampled on acceptance
- in_b  in  WIDTH  operand B, sampled on acceptance
- cmp_clr  out  1  synchronous active-high clear to the comparator
- ser_a  out  1  current serial bit of A, MSB first
- ser_b  out  1  current serial bit of B, MSB first
- ser_valid  out  1  high while ser_a/ser_b carry operand bits
- cmp_less  in  1  comparator a_less_b, combinational from ser_a/ser_b
- cmp_eq  in  1  comparator a_eq_b
- cmp_greater  in  1  comparator a_greater_b
- res_valid  out  1  one-cycle pulse: result fields updated
- res_less  out  1  captured cmp_less
- res_eq  out  1  captured cmp_eq
- res_greater  out  1  captured cmp_greater
- res_err  out  1  captured flags were not exactly one-hot

## Operation
- FSM states: IDLE, CLEAR, SHIFT. Reset state is IDLE.
- Acceptance occurs on any rising edge where in_valid and in_ready are both high.
- On acceptance:
  - in_a and in_b load into shift registers sh_a and sh_b.
  - The bit counter loads WIDTH-1.
  - The state moves to CLEAR.
- in_ready is high in IDLE. It is also high in the SHIFT cycle where the counter equals 0.
- in_ready is low in CLEAR and in every other SHIFT cycle. in_valid and operand changes are ignored while in_ready is low.
- CLEAR lasts one cycle:
  - cmp_clr = 1, ser_valid = 0, ser_a = ser_b = 0.
  - The next state is always SHIFT.
- SHIFT lasts WIDTH cycles:
  - ser_valid = 1, ser_a = sh_a[WIDTH-1], ser_b = sh_b[WIDTH-1].
  - Each edge shifts sh_a and sh_b left by one and decrements the counter.
- Last SHIFT cycle (counter = 0):
  - At that edge, cmp_less/cmp_eq/cmp_greater are captured into res_less/res_eq/res_greater.
  - res_err is set to the inverse of "exactly one flag high".
  - res_valid is set for the next cycle only.
- Exit from the last SHIFT cycle:
  - If a new acceptance occurs on the same edge, the next state is CLEAR.
  - Otherwise the next state is IDLE.
- Outside SHIFT: ser_valid = 0, ser_a = ser_b = 0. cmp_clr is 0 except in CLEAR.
- res_less/res_eq/res_greater/res_err hold their values until the next capture.
- Reset (rst_n low, at any time, including mid-SHIFT):
  - Immediately: state = IDLE, counter = 0, sh_a = sh_b = 0.
  - Outputs: res_valid = 0, res_less = res_eq = res_greater = res_err = 0, cmp_clr = 0, ser_valid = 0, ser_a = ser_b = 0, in_ready = 1 once out of reset.
  - An aborted operation produces no res_valid.

## Timing
- The acceptance edge is E0.
- Cycle 1: CLEAR. cmp_clr is high, so the comparator's state is cleared at edge E1.
- Cycles 2 .. WIDTH+1: SHIFT. The bit with index WIDTH+1-k appears in cycle k.
- The capture edge is the end of cycle WIDTH+1. res_valid is high during cycle WIDTH+2.
- Latency from acceptance to res_valid: WIDTH+2 cycles.
- Sustained throughput with in_valid held high: one pair per WIDTH+1 cycles. There is no IDLE cycle between pairs.
- res_valid for pair n and cmp_clr for pair n+1 can be high in the same cycle; both are legal.
- rst_n deassertion is synchronised externally. The first acceptance can occur on the first rising edge after rst_n rises.

## Test plan
- WIDTH=8, a=0xA5, b=0xA5:
  - ser_a = ser_b = 1,0,1,0,0,1,0,1 over cycles 2..9.
  - res_valid in cycle 10 with res_eq=1, res_less=0, res_greater=0, res_err=0.
- a=0x80, b=0x7F:
  - ser_a = 1,0,0,0,0,0,0,0; ser_b = 0,1,1,1,1,1,1,1.
  - res_greater=1, res_eq=0, res_less=0.
- a=0x12, b=0x13 (differs only at the LSB): res_less=1, res_greater=0, res_eq=0, res_err=0.
- Back-to-back, in_valid held high for pairs (0x01,0x02), (0xFF,0x00), (0x55,0x55):
  - Acceptances 9 cycles apart.
  - in_ready is high only in IDLE and the last SHIFT cycle.
  - cmp_clr pulses once per pair.
  - Results arrive in order: less, greater, eq.
- rst_n pulled low during the 4th SHIFT cycle of a=0xF0, b=0x0F:
  - All outputs take their reset values immediately and no res_valid appears.
  - A following pair a=0x03, b=0x04 completes normally with res_less=1.
- Model forces cmp_less=cmp_greater=1 on the capture cycle: res_err=1 with res_less=1, res_greater=1, res_eq=0.
